// File: rtl/cp0_exc_unit.sv
// cp0_exc_unit
// Memory-stage exception consumer and CP0 register file.
// Picks the highest-priority exception flagged in M, redirects the pipeline
// (flush_o/newpc_o), records BadVAddr/EPC/Cause/Status on the next edge,
// runs the Count/Compare timer and serves MTC0 writes and MFC0 reads.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   validM, pcM, is_in_delayslotM
//                             M-stage instruction context
//   adelM, adesM, bad_addrM   data address errors and faulting address
//   syscallM, breakM, riM, overflowM, eretM
//                             other M-stage exception/return flags
//   int_i[5:0]                external hardware interrupts
//   we_i, waddr_i, data_i     MTC0 write port
//   raddr_i, data_o           MFC0 read port (combinational)
//   excepttype_o, flush_o, newpc_o
//                             selected exception and redirect
//   epc_o, status_o, cause_o  register views for the pipeline
//   timer_int_o               Count==Compare interrupt pending
module cp0_exc_unit #(
  parameter logic [31:0] EXC_ENTRY = 32'hBFC0_0380,
  parameter logic [31:0] PRID_VAL  = 32'h0000_4220,
  parameter int          COUNT_DIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        validM,
  input  logic [31:0] pcM,
  input  logic        is_in_delayslotM,
  input  logic        adelM,
  input  logic        adesM,
  input  logic [31:0] bad_addrM,
  input  logic        syscallM,
  input  logic        breakM,
  input  logic        riM,
  input  logic        overflowM,
  input  logic        eretM,
  input  logic [5:0]  int_i,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  raddr_i,
  output logic [31:0] data_o,
  output logic [31:0] excepttype_o,
  output logic        flush_o,
  output logic [31:0] newpc_o,
  output logic [31:0] epc_o,
  output logic [31:0] status_o,
  output logic [31:0] cause_o,
  output logic        timer_int_o
);

  localparam logic [4:0] R_BADVADDR = 5'd8;
  localparam logic [4:0] R_COUNT    = 5'd9;
  localparam logic [4:0] R_COMPARE  = 5'd11;
  localparam logic [4:0] R_STATUS   = 5'd12;
  localparam logic [4:0] R_CAUSE    = 5'd13;
  localparam logic [4:0] R_EPC      = 5'd14;
  localparam logic [4:0] R_PRID     = 5'd15;

  localparam logic [31:0] T_ERET      = 32'h0000_000e;
  localparam logic [31:0] STATUS_RST  = 32'h0040_0000;
  localparam logic        SINGLE_RATE = (COUNT_DIV == 1);

  logic [31:0] badvaddr, count, compare, status, cause, epc;
  logic        div_tgl;

  logic        int_pending;
  logic [31:0] exc_type;
  logic        exc_badv_we;
  logic [31:0] exc_badv;
  logic [4:0]  exc_code;
  logic        exc_take;
  logic        eret_take;
  logic        mtc0_we;

  // Priority selection of the M-stage exception. Interrupts win over
  // everything, fetch misalignment comes next, ERET is lowest. The
  // BadVAddr source is chosen alongside so fetch and data AdEL, which
  // share a type code, still record different addresses.
  always_comb begin
    int_pending = status[0] & ~status[1] & (|(cause[15:8] & status[15:8]));
    exc_type    = 32'h0;
    exc_badv_we = 1'b0;
    exc_badv    = bad_addrM;
    if (validM) begin
      if (int_pending) begin
        exc_type = 32'h01;
      end else if (pcM[1:0] != 2'b00) begin
        exc_type    = 32'h04;
        exc_badv_we = 1'b1;
        exc_badv    = pcM;
      end else if (riM) begin
        exc_type = 32'h0a;
      end else if (syscallM) begin
        exc_type = 32'h08;
      end else if (breakM) begin
        exc_type = 32'h09;
      end else if (overflowM) begin
        exc_type = 32'h0c;
      end else if (adelM) begin
        exc_type    = 32'h04;
        exc_badv_we = 1'b1;
      end else if (adesM) begin
        exc_type    = 32'h05;
        exc_badv_we = 1'b1;
      end else if (eretM) begin
        exc_type = T_ERET;
      end
    end
  end

  // The interrupt type code is 1 but its ExcCode is 0; every other type
  // code doubles as its ExcCode.
  assign exc_code     = (exc_type == 32'h01) ? 5'd0 : exc_type[4:0];
  assign excepttype_o = exc_type;
  assign flush_o      = (exc_type != 32'h0);
  assign newpc_o      = (exc_type == T_ERET) ? epc : EXC_ENTRY;
  assign eret_take    = (exc_type == T_ERET);
  assign exc_take     = flush_o & ~eret_take;
  // Any redirect in M kills the MTC0 sitting in the same stage.
  assign mtc0_we      = we_i & ~flush_o;

  // Status: EXL is owned by exception entry/return; MTC0 reaches IM, EXL, IE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= STATUS_RST;
    end else if (exc_take) begin
      status[1] <= 1'b1;
    end else if (eret_take) begin
      status[1] <= 1'b0;
    end else if (mtc0_we && waddr_i == R_STATUS) begin
      status[15:8] <= data_i[15:8];
      status[1:0]  <= data_i[1:0];
    end
  end

  // Cause: hardware IP bits follow the interrupt lines every cycle; BD is
  // only captured on a first-level exception so nested faults keep the
  // original return context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cause <= 32'h0;
    end else begin
      cause[15:10] <= {int_i[5] | timer_int_o, int_i[4:0]};
      if (exc_take) begin
        cause[6:2] <= exc_code;
        if (!status[1]) begin
          cause[31] <= is_in_delayslotM;
        end
      end else if (mtc0_we && waddr_i == R_CAUSE) begin
        cause[9:8] <= data_i[9:8];
      end
    end
  end

  // EPC points back at the branch when the faulting instruction sits in a
  // delay slot, so ERET re-executes the branch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      epc <= 32'h0;
    end else if (exc_take) begin
      if (!status[1]) begin
        epc <= is_in_delayslotM ? (pcM - 32'd4) : pcM;
      end
    end else if (mtc0_we && waddr_i == R_EPC) begin
      epc <= data_i;
    end
  end

  // BadVAddr is read-only to software and only moves on address errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      badvaddr <= 32'h0;
    end else if (exc_take && exc_badv_we) begin
      badvaddr <= exc_badv;
    end
  end

  // Count runs at half the clock rate through a toggle unless configured
  // for full rate; a software load restarts the half-rate phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= 32'h0;
      div_tgl <= 1'b0;
    end else if (mtc0_we && waddr_i == R_COUNT) begin
      count   <= data_i;
      div_tgl <= 1'b0;
    end else begin
      div_tgl <= ~div_tgl;
      if (SINGLE_RATE || div_tgl) begin
        count <= count + 32'd1;
      end
    end
  end

  // Compare register and the sticky timer interrupt it acknowledges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      compare     <= 32'h0;
      timer_int_o <= 1'b0;
    end else if (mtc0_we && waddr_i == R_COMPARE) begin
      compare     <= data_i;
      timer_int_o <= 1'b0;
    end else if (compare != 32'h0 && count == compare) begin
      timer_int_o <= 1'b1;
    end
  end

  // MFC0 read mux; unimplemented register numbers read as zero.
  always_comb begin
    data_o = 32'h0;
    case (raddr_i)
      R_BADVADDR: data_o = badvaddr;
      R_COUNT:    data_o = count;
      R_COMPARE:  data_o = compare;
      R_STATUS:   data_o = status;
      R_CAUSE:    data_o = cause;
      R_EPC:      data_o = epc;
      R_PRID:     data_o = PRID_VAL;
      default:    data_o = 32'h0;
    endcase
  end

  assign epc_o    = epc;
  assign status_o = status;
  assign cause_o  = cause;

endmodule
